ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte, such as 0xF4 "enable data reporting" or 0xFF "reset", from the FPGA to the mouse using the PS/2 request-to-send sequence. It drives the bidirectional PS/2 clock and data lines through open-drain enables. It sits beside the existing mouse receiver on the same pins. It signals busy so the receiver ignores clock edges generated during a host transmission.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency.
INHIBIT_US, 100, minimum time PS/2 clock is held low before the start bit.
TIMEOUT_US, 15_000, maximum time from clock release to acknowledge before the transfer is abandoned.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
ps2_clk_in  input  1  sampled PS/2 clock pin, asynchronous.
ps2_data_in  input  1  sampled PS/2 data pin, asynchronous.
ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release (high-Z).
ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
tx_data  input  8  command byte; captured when tx_valid && tx_ready.
tx_valid  input  1  request to send.
tx_ready  output  1  high only in IDLE.
busy  output  1  high in every state except IDLE.
tx_done  output  1  one-cycle pulse: device acknowledged.
tx_err  output  1  one-cycle pulse: timeout or missing ack.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ps2_clk_oe=0, ps2_data_oe=0; tx_ready=1, busy=0, tx_done=0, tx_err=0; all counters cleared. Lines are released the same cycle reset asserts, including mid-transfer.
- Input conditioning: 2-FF synchronizers on ps2_clk_in and ps2_data_in. A falling edge is sync_prev=1 and sync_cur=0.
- INHIBIT_CYC = CLK_FREQ_HZ/1_000_000*INHIBIT_US (default 5000). TIMEOUT_CYC is computed the same way (default 750_000). Counter width is $clog2(TIMEOUT_CYC+1).
- States and transitions:
  - IDLE: if tx_valid, capture tx_data and compute odd parity (parity = ~^tx_data). Go to INHIBIT. tx_valid while busy is ignored.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYC cycles, then go to REQ.
  - REQ: hold data_oe=1 (start bit 0) for one cycle with clk_oe still 1. Then set clk_oe=0, clear the timeout counter, and go to SEND with bit_idx=0.
  - SEND: on each synchronized falling edge of the PS/2 clock, drive the next bit with data_oe = ~bit.
    - bit_idx 0-7: data bits, LSB first.
    - bit_idx 8: parity.
    - bit_idx 9: stop, data_oe=0. Go to ACK.
  - ACK: on the next falling edge, sample synchronized data. 0 → go to WAIT_REL. 1 → tx_err pulse, go to IDLE.
  - WAIT_REL: wait until synchronized clock and data are both 1. Then tx_done pulse, go to IDLE.
- Timeout: counter runs in SEND, ACK and WAIT_REL. When it reaches TIMEOUT_CYC, force data_oe=0 and clk_oe=0, pulse tx_err, and go to IDLE. Timeout has priority over an edge arriving in the same cycle.
- tx_done and tx_err are never asserted in the same cycle. tx_ready reasserts in the cycle after either pulse.
- Falling edges seen in IDLE, INHIBIT or REQ are ignored.
- Latency: the first device clock edge occurs at least INHIBIT_CYC+1 cycles after capture.

Decomposition:
- Package ps2_pkg holds:
  - the state enum ps2_tx_state_t (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL);
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RESP_ACK=8'hFA;
  - frame constant PS2_FRAME_BITS=11.
- One sub-module, ps2_sync_edge: 2-FF synchronizer plus falling-edge detect, instantiated twice. The receiver is to share it.

Test Plan:
- tx_data=0xF4 with a device model clocking at 12.5 kHz → data line after start bit reads 0,0,1,0,1,1,1,1, parity 0, stop 1. Model pulls ack low → tx_done pulses once, tx_err stays 0.
- tx_data=0xFF → eight 1 data bits, parity bit 1, and tx_done.
- Check the inhibit window: ps2_clk_oe high for exactly 5000 cycles before ps2_data_oe rises, both high together for 1 cycle, then clk_oe drops.
- Device never clocks → tx_err pulses exactly 750_000 cycles after clk release, both oe=0, tx_ready=1.
- Device model leaves data high at the 11th edge (no ack) → tx_err, no tx_done.
- Assert reset low during SEND bit 4 → clk_oe and data_oe go to 0 asynchronously. After release, a new tx_valid with 0xF4 completes normally. A tx_valid pulsed during busy is not sent.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmitter types and constants
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_REL
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;
    localparam int         PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-FF synchronizer with falling-edge detect for a PS/2 line
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall
);
    import ps2_pkg::*;

    logic meta;
    logic cur;
    logic prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            cur  <= meta;
            prev <= cur;
        end
    end

    assign level = cur;
    assign fall  = prev & ~cur;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (request-to-send)
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    import ps2_pkg::*;

    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    ps2_tx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       frame;
    logic [3:0]       bit_idx;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            frame       <= '0;
            bit_idx     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        frame      <= {odd_parity(tx_data), tx_data};
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    bit_idx    <= '0;
                    state      <= SEND;
                end
                default: begin
                    // Device-clocked phases share one timeout; it beats any edge in the same cycle.
                    cnt <= cnt + 1'b1;
                    if (cnt == TO_LAST) begin
                        ps2_data_oe <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        tx_err      <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        case (state)
                            SEND: begin
                                if (clk_fall) begin
                                    if (bit_idx == 4'd9) begin
                                        ps2_data_oe <= 1'b0;
                                        state       <= ACK;
                                    end else begin
                                        ps2_data_oe <= ~frame[bit_idx];
                                        bit_idx     <= bit_idx + 1'b1;
                                    end
                                end
                            end
                            ACK: begin
                                if (clk_fall) begin
                                    if (data_level) begin
                                        tx_err <= 1'b1;
                                        busy   <= 1'b0;
                                        state  <= IDLE;
                                    end else begin
                                        state <= WAIT_REL;
                                    end
                                end
                            end
                            WAIT_REL: begin
                                if (clk_level && data_level) begin
                                    tx_done <= 1'b1;
                                    busy    <= 1'b0;
                                    state   <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
